reg_file_mp: RTL and testbench

- Parametrised multi-port integer register file for the pipeline. Successor to the single-write, dual-read file.
- Provides NUM_RD asynchronous read ports and NUM_WR posedge write-back ports.
- Keeps a per-register busy scoreboard so the decode stage can detect RAW hazards.
- Provides a handshaked debug access port, replacing the fire-and-forget debug write.
- Sits between decode (reads, issue marking) and write-back (writes, scoreboard clears).

---
 rtl/pcore_rf_pkg.sv | 30 +++
 rtl/rf_scoreboard.sv | 84 ++++++++
 rtl/reg_file_mp.sv | 173 +++++++++++++++++
 tb/tb_reg_file_mp.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcore_rf_pkg.sv
// ---------------------------------------------------------------------------
// pcore_rf_pkg
// Shared definitions for the multi-port integer register file.
//   - Default data width and register count used by reg_file_mp.
//   - Debug access FSM state type (type_rf_dbg_states_e).
//   - Debug request bundle (type_rf_dbg_req_s), sized for the default
//     configuration, used by agents that drive the debug access port.
// ---------------------------------------------------------------------------
package pcore_rf_pkg;

   localparam int XLEN_DEFAULT     = 32;
   localparam int RF_DEPTH_DEFAULT = 32;
   localparam int AW_DEFAULT       = $clog2(RF_DEPTH_DEFAULT);

   // Debug access sequencing: idle, performing the access, acknowledging.
   typedef enum logic [1:0] {
      DBG_IDLE   = 2'd0,
      DBG_ACCESS = 2'd1,
      DBG_ACK    = 2'd2
   } type_rf_dbg_states_e;

   // One debug request as seen on the debug access port.
   typedef struct packed {
      logic                    req;
      logic                    we;
      logic [AW_DEFAULT-1:0]   addr;
      logic [XLEN_DEFAULT-1:0] wdata;
   } type_rf_dbg_req_s;

endpackage

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// Per-register busy bits used by decode to detect RAW hazards.
// Optional feature macro: RF_BYPASS_EN (a read port whose address matches a
// same-cycle write-back reports not-busy).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   rd_addr_i    NUM_RD read addresses (port k at slice k)
//   rd_busy_o    busy flag of each addressed register
//   wr_req_i     write-back valid per port (clears busy)
//   wr_addr_i    write-back addresses
//   iss_req_i    issue of an instruction writing iss_addr_i (sets busy)
//   iss_addr_i   destination register of the issued instruction
//   flush_i      clears every busy bit
// ---------------------------------------------------------------------------
module rf_scoreboard #(
   parameter int RF_DEPTH = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   localparam int AW      = $clog2(RF_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_RD*AW-1:0] rd_addr_i,
   output logic [NUM_RD-1:0]    rd_busy_o,
   input  logic [NUM_WR-1:0]    wr_req_i,
   input  logic [NUM_WR*AW-1:0] wr_addr_i,
   input  logic                 iss_req_i,
   input  logic [AW-1:0]        iss_addr_i,
   input  logic                 flush_i
);

   logic [RF_DEPTH-1:0] busy_q;
   logic [RF_DEPTH-1:0] busy_d;
   logic [AW-1:0]       lookAddr;

   // Next busy vector. Ordering encodes priority: write-back clears first,
   // a same-cycle issue then re-sets (newer producer wins), and flush
   // overrides everything. x0 never becomes busy.
   always_comb begin
      busy_d = busy_q;
      for (int p = 0; p < NUM_WR; p++) begin
         if (wr_req_i[p]) begin
            busy_d[wr_addr_i[p*AW +: AW]] = 1'b0;
         end
      end
      if (iss_req_i && (iss_addr_i != '0)) begin
         busy_d[iss_addr_i] = 1'b1;
      end
      if (flush_i) begin
         busy_d = '0;
      end
      busy_d[0] = 1'b0;
   end

   // Busy vector register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // Busy lookup per read port. With forwarding enabled, a register being
   // written back this very cycle already has its value available, so it
   // is reported as not busy.
   always_comb begin
      rd_busy_o = '0;
      lookAddr  = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         lookAddr     = rd_addr_i[k*AW +: AW];
         rd_busy_o[k] = busy_q[lookAddr];
`ifdef RF_BYPASS_EN
         for (int p = 0; p < NUM_WR; p++) begin
            if (wr_req_i[p] && (lookAddr != '0) && (wr_addr_i[p*AW +: AW] == lookAddr)) begin
               rd_busy_o[k] = 1'b0;
            end
         end
`endif
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
// Parametrised multi-port integer register file with busy scoreboard and a
// handshaked debug access port.
// Optional feature macro: RF_BYPASS_EN (same-cycle write-back data is
// forwarded to matching read ports).
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   rd_addr_i        NUM_RD read addresses
//   rd_data_o        NUM_RD combinational read data
//   rd_busy_o        busy flag of each addressed register
//   wr_req_i         write-back valid per port
//   wr_addr_i        write-back addresses
//   wr_data_i        write-back data
//   iss_req_i        decode issued an instruction writing iss_addr_i
//   iss_addr_i       destination register of the issued instruction
//   flush_i          pipeline flush, clears all busy bits
//   dbg_req_i        debug request, held until dbg_ack_o
//   dbg_we_i         debug direction (1 = write)
//   dbg_addr_i       debug register address
//   dbg_wdata_i      debug write data
//   dbg_ack_o        one-cycle completion pulse
//   dbg_rdata_o      debug read data, valid with dbg_ack_o
// ---------------------------------------------------------------------------
module reg_file_mp
   import pcore_rf_pkg::*;
#(
   parameter int XLEN     = XLEN_DEFAULT,
   parameter int RF_DEPTH = RF_DEPTH_DEFAULT,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   localparam int AW      = $clog2(RF_DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_RD*AW-1:0]   rd_addr_i,
   output logic [NUM_RD*XLEN-1:0] rd_data_o,
   output logic [NUM_RD-1:0]      rd_busy_o,
   input  logic [NUM_WR-1:0]      wr_req_i,
   input  logic [NUM_WR*AW-1:0]   wr_addr_i,
   input  logic [NUM_WR*XLEN-1:0] wr_data_i,
   input  logic                   iss_req_i,
   input  logic [AW-1:0]          iss_addr_i,
   input  logic                   flush_i,
   input  logic                   dbg_req_i,
   input  logic                   dbg_we_i,
   input  logic [AW-1:0]          dbg_addr_i,
   input  logic [XLEN-1:0]        dbg_wdata_i,
   output logic                   dbg_ack_o,
   output logic [XLEN-1:0]        dbg_rdata_o
);

   logic [XLEN-1:0]     regs_q [RF_DEPTH];
   logic [XLEN-1:0]     regs_d [RF_DEPTH];
   type_rf_dbg_states_e dbgState_q;
   type_rf_dbg_states_e dbgState_d;
   logic [XLEN-1:0]     dbgRdata_q;
   logic [XLEN-1:0]     dbgRdata_d;
   logic                dbgWrEn;
   logic                wrAny;
   logic [AW-1:0]       rdAddr;

   assign wrAny = |wr_req_i;

   // Debug FSM next-state logic. A debug write yields to any write-back in
   // the same cycle so the array never needs a third write port; it simply
   // waits in DBG_ACCESS until write-back goes quiet.
   always_comb begin
      dbgState_d = dbgState_q;
      dbgRdata_d = dbgRdata_q;
      dbgWrEn    = 1'b0;
      case (dbgState_q)
         DBG_IDLE: begin
            if (dbg_req_i) begin
               dbgState_d = DBG_ACCESS;
            end
         end
         DBG_ACCESS: begin
            if (!dbg_we_i) begin
               dbgRdata_d = regs_q[dbg_addr_i];
               dbgState_d = DBG_ACK;
            end else if (!wrAny) begin
               dbgWrEn    = 1'b1;
               dbgState_d = DBG_ACK;
            end
         end
         DBG_ACK: begin
            dbgState_d = DBG_IDLE;
         end
         default: begin
            dbgState_d = DBG_IDLE;
         end
      endcase
   end

   // Debug FSM state and captured read data. Reset drops any transaction
   // in flight, so an aborted request never sees an ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dbgState_q <= DBG_IDLE;
         dbgRdata_q <= '0;
      end else begin
         dbgState_q <= dbgState_d;
         dbgRdata_q <= dbgRdata_d;
      end
   end

   assign dbg_ack_o   = (dbgState_q == DBG_ACK);
   assign dbg_rdata_o = dbgRdata_q;

   // Next array contents. Write-back ports are applied in ascending index
   // order so the highest port wins on an address collision. Entry 0 is
   // forced to zero, which drops every kind of write to x0.
   always_comb begin
      regs_d = regs_q;
      if (dbgWrEn) begin
         regs_d[dbg_addr_i] = dbg_wdata_i;
      end
      for (int p = 0; p < NUM_WR; p++) begin
         if (wr_req_i[p]) begin
            regs_d[wr_addr_i[p*AW +: AW]] = wr_data_i[p*XLEN +: XLEN];
         end
      end
      regs_d[0] = '0;
   end

   // Register array.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RF_DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Asynchronous read ports. With forwarding enabled, the highest-index
   // matching write-back port supplies the data instead of the array.
   always_comb begin
      rd_data_o = '0;
      rdAddr    = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         rdAddr                    = rd_addr_i[k*AW +: AW];
         rd_data_o[k*XLEN +: XLEN] = regs_q[rdAddr];
`ifdef RF_BYPASS_EN
         for (int p = 0; p < NUM_WR; p++) begin
            if (wr_req_i[p] && (rdAddr != '0) && (wr_addr_i[p*AW +: AW] == rdAddr)) begin
               rd_data_o[k*XLEN +: XLEN] = wr_data_i[p*XLEN +: XLEN];
            end
         end
`endif
      end
   end

   // Hazard scoreboard.
   rf_scoreboard #(
      .RF_DEPTH (RF_DEPTH),
      .NUM_RD   (NUM_RD),
      .NUM_WR   (NUM_WR)
   ) uScoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_addr_i  (rd_addr_i),
      .rd_busy_o  (rd_busy_o),
      .wr_req_i   (wr_req_i),
      .wr_addr_i  (wr_addr_i),
      .iss_req_i  (iss_req_i),
      .iss_addr_i (iss_addr_i),
      .flush_i    (flush_i)
   );

endmodule

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp
// Self-checking bench for reg_file_mp with two read and two write-back
// ports. Honours RF_BYPASS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_reg_file_mp;
   import pcore_rf_pkg::*;

   localparam int XLEN     = 32;
   localparam int RF_DEPTH = 32;
   localparam int NUM_RD   = 2;
   localparam int NUM_WR   = 2;
   localparam int AW       = 5;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [NUM_RD*AW-1:0]   rd_addr;
   logic [NUM_RD*XLEN-1:0] rd_data;
   logic [NUM_RD-1:0]      rd_busy;
   logic [NUM_WR-1:0]      wr_req;
   logic [NUM_WR*AW-1:0]   wr_addr;
   logic [NUM_WR*XLEN-1:0] wr_data;
   logic                   iss_req;
   logic [AW-1:0]          iss_addr;
   logic                   flush;
   type_rf_dbg_req_s       dbgReq;
   logic                   dbg_ack;
   logic [XLEN-1:0]        dbg_rdata;

   logic [31:0] modelRegs [32];
   logic        modelBusy [32];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   reg_file_mp #(
      .XLEN     (XLEN),
      .RF_DEPTH (RF_DEPTH),
      .NUM_RD   (NUM_RD),
      .NUM_WR   (NUM_WR)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_addr_i   (rd_addr),
      .rd_data_o   (rd_data),
      .rd_busy_o   (rd_busy),
      .wr_req_i    (wr_req),
      .wr_addr_i   (wr_addr),
      .wr_data_i   (wr_data),
      .iss_req_i   (iss_req),
      .iss_addr_i  (iss_addr),
      .flush_i     (flush),
      .dbg_req_i   (dbgReq.req),
      .dbg_we_i    (dbgReq.we),
      .dbg_addr_i  (dbgReq.addr),
      .dbg_wdata_i (dbgReq.wdata),
      .dbg_ack_o   (dbg_ack),
      .dbg_rdata_o (dbg_rdata)
   );

   // Single comparison point: counts, and reports on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's worth of datapath inputs after the falling edge.
   task automatic applyStimulus(input logic [1:0] wreq, input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic [4:0] wa1, input logic [31:0] wd1, input logic iss,
                                input logic [4:0] ia, input logic fl, input logic [4:0] ra0,
                                input logic [4:0] ra1);
      @(negedge clk);
      wr_req   = wreq;
      wr_addr  = {wa1, wa0};
      wr_data  = {wd1, wd0};
      iss_req  = iss;
      iss_addr = ia;
      flush    = fl;
      rd_addr  = {ra1, ra0};
      #1;
   endtask

   // Expected read data: array contents, or forwarded write-back data.
   function automatic logic [31:0] expData(input logic [4:0] a);
      logic [31:0] v;
      v = modelRegs[a];
`ifdef RF_BYPASS_EN
      if (wr_req[0] && wr_addr[4:0] == a) v = wr_data[31:0];
      if (wr_req[1] && wr_addr[9:5] == a) v = wr_data[63:32];
`endif
      if (a == 5'd0) v = '0;
      return v;
   endfunction

   function automatic logic expBusy(input logic [4:0] a);
      logic b;
      b = modelBusy[a];
`ifdef RF_BYPASS_EN
      if ((wr_req[0] && wr_addr[4:0] == a) || (wr_req[1] && wr_addr[9:5] == a)) b = 1'b0;
`endif
      if (a == 5'd0) b = 1'b0;
      return b;
   endfunction

   task automatic checkReads(input string tag);
      checkOutput({tag, "_rd0"}, rd_data[31:0], expData(rd_addr[4:0]));
      checkOutput({tag, "_rd1"}, rd_data[63:32], expData(rd_addr[9:5]));
      checkOutput({tag, "_busy0"}, 32'(rd_busy[0]), 32'(expBusy(rd_addr[4:0])));
      checkOutput({tag, "_busy1"}, 32'(rd_busy[1]), 32'(expBusy(rd_addr[9:5])));
   endtask

   // Advance past a rising edge and update the model from the applied inputs:
   // per register, newest write-back port wins; busy follows flush > issue >
   // write-back > hold.
   task automatic tick();
      logic [31:0] nr [32];
      logic        nb [32];
      @(posedge clk);
      for (int r = 0; r < 32; r++) begin
         logic w0, w1, isr;
         w0  = wr_req[0] && (wr_addr[4:0] == 5'(r));
         w1  = wr_req[1] && (wr_addr[9:5] == 5'(r));
         isr = iss_req && (iss_addr == 5'(r));
         nr[r] = w1 ? wr_data[63:32] : (w0 ? wr_data[31:0] : modelRegs[r]);
         nb[r] = flush ? 1'b0 : (isr ? 1'b1 : ((w0 || w1) ? 1'b0 : modelBusy[r]));
      end
      nr[0] = '0;
      nb[0] = 1'b0;
      modelRegs = nr;
      modelBusy = nb;
      #1;
   endtask

   // One debug transaction; write-back on port 0 (to x31) is held busy for
   // the first wrHold cycles. Returns request-to-ack latency in cycles.
   task automatic dbgAccess(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                            input int wrHold, output int lat, output logic [31:0] rdata);
      lat   = -1;
      rdata = '0;
      for (int c = 1; c <= 20 && lat < 0; c++) begin
         @(negedge clk);
         dbgReq   = '{req: 1'b1, we: we, addr: addr, wdata: wdata};
         iss_req  = 1'b0;
         flush    = 1'b0;
         wr_addr  = {5'd0, 5'd31};
         wr_data  = {32'd0, 32'(c) * 32'h0101_0101};
         wr_req   = (c <= wrHold) ? 2'b01 : 2'b00;
         tick();
         if (dbg_ack) begin
            lat   = c;
            rdata = dbg_rdata;
         end
      end
      @(negedge clk);
      dbgReq = '0;
      wr_req = '0;
      if (lat > 0 && we && addr != 5'd0) modelRegs[addr] = wdata;
      tick();
      checkOutput("dbg_ack_single", 32'(dbg_ack), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int          lat;
      logic [31:0] rdv;
      logic [4:0]  a0, a1, r0, r1;
      logic [31:0] d0, d1;

      for (int i = 0; i < 32; i++) begin
         modelRegs[i] = '0;
         modelBusy[i] = 1'b0;
      end
      dbgReq = '0; wr_req = '0; wr_addr = '0; wr_data = '0;
      iss_req = 1'b0; iss_addr = '0; flush = 1'b0; rd_addr = {5'd5, 5'd0};
      #1;
      checkOutput("reset_ack", 32'(dbg_ack), 32'd0);
      checkOutput("reset_rdata", dbg_rdata, 32'd0);
      checkReads("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic write and read-back, plus x0 drop
      applyStimulus(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0);
      checkReads("wr_x5_same");
      tick();
      applyStimulus(2'b01, 5'd0, 32'hCAFE_F00D, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 5'd5, 5'd0);
      checkOutput("x5_readback", rd_data[31:0], 32'hDEAD_BEEF);
      tick();
      applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
      checkOutput("x0_data", rd_data[31:0], 32'd0);
      checkOutput("x0_busy", 32'(rd_busy[0]), 32'd0);
      tick();

      // Two ports collide on x7
      applyStimulus(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7);
      checkReads("x7_collide");
      tick();
      applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd5);
      checkOutput("x7_high_wins", rd_data[31:0], 32'h22);
      checkReads("x7_after");
      tick();

      // Scoreboard set, set-beats-clear, flush
      applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd3);
      tick();
      applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd5);
      checkOutput("x3_busy", 32'(rd_busy[0]), 32'd1);
      tick();
      applyStimulus(2'b10, 5'd0, 32'd0, 5'd3, 32'h33, 1'b1, 5'd3, 1'b0, 5'd5, 5'd5);
      tick();
      applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd10, 1'b1, 5'd3, 5'd10);
      checkOutput("x3_set_wins", 32'(rd_busy[0]), 32'd1);
      tick();
      applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd10);
      checkOutput("flush_x3", 32'(rd_busy[0]), 32'd0);
      checkOutput("flush_beats_iss", 32'(rd_busy[1]), 32'd0);
      checkReads("flush");
      tick();

      // Same-cycle write and read of x4 that is busy
      applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 5'd4, 5'd4);
      tick();
      applyStimulus(2'b01, 5'd4, 32'h1234, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd4, 5'd4);
`ifdef RF_BYPASS_EN
      checkOutput("bypass_data", rd_data[31:0], 32'h1234);
      checkOutput("bypass_busy", 32'(rd_busy[0]), 32'd0);
`else
      checkOutput("nobypass_data", rd_data[31:0], 32'd0);
      checkOutput("nobypass_busy", 32'(rd_busy[0]), 32'd1);
`endif
      checkReads("x4_same");
      tick();
      applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd4, 5'd4);
      checkReads("x4_after");
      tick();

      // Debug write held off by write-back, then debug read
      dbgAccess(1'b1, 5'd9, 32'hA5A5_A5A5, 3, lat, rdv);
      checkOutput("dbg_wr_latency", 32'(lat), 32'd4);
      dbgAccess(1'b0, 5'd9, 32'd0, 0, lat, rdv);
      checkOutput("dbg_rd_latency", 32'(lat), 32'd2);
      checkOutput("dbg_rd_data", rdv, 32'hA5A5_A5A5);
      dbgAccess(1'b1, 5'd0, 32'hFFFF_FFFF, 0, lat, rdv);
      checkOutput("dbg_wr_x0_latency", 32'(lat), 32'd2);
      applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9);
      checkReads("dbg_after");
      tick();

      // Randomized traffic against the model
      for (int n = 0; n < 300; n++) begin
         a0 = 5'($urandom_range(0, 31));
         a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 31));
         d0 = $urandom;
         d1 = $urandom;
         r0 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 31));
         r1 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
         applyStimulus(2'($urandom_range(0, 3)), a0, d0, a1, d1,
                       ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
                       ($urandom_range(0, 15) == 0), r0, r1);
         checkReads("rand");
         tick();
      end

      // Reset in the middle of a stalled debug write
      applyStimulus(2'b01, 5'd12, 32'h55, 5'd0, 32'd0, 1'b1, 5'd13, 1'b0, 5'd12, 5'd13);
      tick();
      @(negedge clk);
      dbgReq  = '{req: 1'b1, we: 1'b1, addr: 5'd9, wdata: 32'hFFFF_0000};
      iss_req = 1'b0;
      wr_req  = 2'b01;
      wr_addr = {5'd0, 5'd31};
      wr_data = {32'd0, 32'h77};
      tick();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_ack", 32'(dbg_ack), 32'd0);
      @(negedge clk);
      dbgReq = '0;
      wr_req = '0;
      for (int i = 0; i < 32; i++) begin
         modelRegs[i] = '0;
         modelBusy[i] = 1'b0;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'(2 * i), 5'(2 * i + 1));
         checkReads("post_reset");
         checkOutput("post_reset_ack", 32'(dbg_ack), 32'd0);
         if (i == 6) begin
            checkOutput("post_reset_x12", rd_data[31:0], 32'd0);
            checkOutput("post_reset_x13_busy", 32'(rd_busy[1]), 32'd0);
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
